// File: rtl/toll_speed_gate_pkg.sv
// Shared constants and state encodings for the toll/speed station controller.
package toll_speed_gate_pkg;

    localparam int unsigned DIST_CONST = 360000;
    localparam int unsigned DIVIDEND_W = 19;
    localparam int unsigned T_WIDTH    = 13;
    localparam int unsigned SPEED_MAX  = 16383;

    localparam logic [1:0] EPASS_VALID   = 2'b10;
    localparam logic [1:0] EPASS_INVALID = 2'b01;

    typedef enum logic [1:0] {IDLE, TIMING, DIVIDE, SEND} meas_state_t;
    typedef enum logic {CLOSED, OPEN} barrier_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses 20 cycles after start.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 19,
    parameter int unsigned DIVISOR_W  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int unsigned CW = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVIDEND_W-1:0] quo;
    logic [CW-1:0]         cnt;
    logic                  busy;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;

    always_comb begin
        shifted = {rem, quo[DIVIDEND_W-1]};
        diff    = shifted - {1'b0, dsr};
    end

    // A zero divisor always "fits", so the quotient comes out all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            dsr  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                quo  <= dividend;
                rem  <= '0;
                dsr  <= divisor;
                cnt  <= CW'(DIVIDEND_W);
                busy <= 1'b1;
            end else if (busy) begin
                if (shifted >= {1'b0, dsr}) begin
                    rem <= diff[DIVISOR_W-1:0];
                    quo <= {quo[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    rem <= shifted[DIVISOR_W-1:0];
                    quo <= {quo[DIVIDEND_W-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; accepts a new byte in the final stop-bit cycle for gapless frames.
module uart_tx #(
    parameter int unsigned SYS_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       ready
);

    localparam int unsigned BIT_CYCLES = SYS_FREQ / BAUD;
    localparam int unsigned BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BIT_LAST = BAUD_W'(BIT_CYCLES - 1);

    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [8:0]        shreg;
    logic              last;

    always_comb begin
        last  = busy && (bit_idx == 4'd9) && (baud_cnt == BIT_LAST);
        ready = !busy || last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
        end else if (start && ready) begin
            tx       <= 1'b0;
            shreg    <= {1'b1, data};
            bit_idx  <= '0;
            baud_cnt <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (baud_cnt == BIT_LAST) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/toll_speed_gate.sv
// Toll/speed station top: sensor timing, speed division, UART report and barrier control.
module toll_speed_gate
    import toll_speed_gate_pkg::*;
#(
    parameter int unsigned SYS_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned WIDTH_SPEED = 14
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor1,
    input  logic       sensor2,
    input  logic       sensor3,
    input  logic [1:0] valid_Epass,
    input  logic       enable,
    output logic       barrier,
    output logic       serial_data_out
);

    localparam logic [15:0] TICK_LAST = 16'(SYS_FREQ / 1000 - 1);

    logic [2:0]  s1_sh, s3_sh;
    logic [1:0]  s2_sh, ep_m, ep_s;
    logic        s1_rise, s3_rise, s3_fall, ms_tick;
    logic [15:0] presc;

    meas_state_t          mstate;
    barrier_state_t       bstate;
    logic [T_WIDTH-1:0]   t;
    logic                 div_start, div_done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [WIDTH_SPEED-1:0] speed;
    logic [15:0]          speed_word;
    logic [7:0]           tx_byte, lo_byte;
    logic                 tx_req, low_pending, uart_busy, uart_ready;

    always_comb begin
        s1_rise    = s1_sh[1] & ~s1_sh[2];
        s3_rise    = s3_sh[1] & ~s3_sh[2];
        s3_fall    = ~s3_sh[1] & s3_sh[2];
        ms_tick    = (presc == TICK_LAST);
        speed      = (quotient > DIVIDEND_W'(SPEED_MAX)) ? WIDTH_SPEED'(SPEED_MAX)
                                                         : WIDTH_SPEED'(quotient);
        speed_word = 16'(speed);
        barrier    = (bstate == OPEN) | enable;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            s1_sh <= '0;
            s2_sh <= '0;
            s3_sh <= '0;
            ep_m  <= '0;
            ep_s  <= '0;
            presc <= '0;
        end else begin
            s1_sh <= {s1_sh[1:0], sensor1};
            s2_sh <= {s2_sh[0], sensor2};
            s3_sh <= {s3_sh[1:0], sensor3};
            ep_m  <= valid_Epass;
            ep_s  <= ep_m;
            presc <= (s1_rise || ms_tick) ? '0 : presc + 1'b1;
        end
    end

    // t picks up a tick landing on the s3 edge; the divider samples it one cycle later.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            mstate      <= IDLE;
            t           <= '0;
            div_start   <= 1'b0;
            tx_req      <= 1'b0;
            tx_byte     <= '0;
            lo_byte     <= '0;
            low_pending <= 1'b0;
        end else begin
            case (mstate)
                IDLE: begin
                    if (s1_rise) begin
                        mstate <= TIMING;
                        t      <= '0;
                    end
                end
                TIMING: begin
                    if (s3_rise) begin
                        mstate    <= DIVIDE;
                        div_start <= 1'b1;
                        if (ms_tick) t <= t + 1'b1;
                    end else if (t == '1) begin
                        mstate <= IDLE;
                    end else if (ms_tick) begin
                        t <= t + 1'b1;
                    end
                end
                DIVIDE: begin
                    div_start <= 1'b0;
                    if (div_done) begin
                        tx_byte     <= speed_word[15:8];
                        lo_byte     <= speed_word[7:0];
                        tx_req      <= 1'b1;
                        low_pending <= 1'b1;
                        mstate      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_req && uart_ready) begin
                        if (low_pending) begin
                            tx_byte     <= lo_byte;
                            low_pending <= 1'b0;
                        end else begin
                            tx_req <= 1'b0;
                        end
                    end else if (!tx_req && !uart_busy) begin
                        mstate <= IDLE;
                    end
                end
                default: mstate <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            bstate <= CLOSED;
        end else begin
            case (bstate)
                CLOSED: if (s2_sh[1] && ep_s == EPASS_VALID) bstate <= OPEN;
                OPEN:   if (s3_fall) bstate <= CLOSED;
                default: bstate <= CLOSED;
            endcase
        end
    end

    seq_divider #(
        .DIVIDEND_W(DIVIDEND_W),
        .DIVISOR_W (T_WIDTH)
    ) u_div (
        .clk     (clk),
        .rst     (reset_n),
        .start   (div_start),
        .dividend(DIVIDEND_W'(DIST_CONST)),
        .divisor (t),
        .quotient(quotient),
        .done    (div_done)
    );

    uart_tx #(
        .SYS_FREQ(SYS_FREQ),
        .BAUD    (BAUD)
    ) u_uart (
        .clk  (clk),
        .rst  (reset_n),
        .start(tx_req),
        .data (tx_byte),
        .tx   (serial_data_out),
        .busy (uart_busy),
        .ready(uart_ready)
    );

endmodule

// File: tb/tb_toll_speed_gate.sv
// Scoreboard bench for toll_speed_gate with a scaled clock (3 cycles per ms, 3 cycles per bit).
module tb_toll_speed_gate;

    localparam int unsigned SYS_FREQ = 3000;
    localparam int unsigned BAUD     = 1000;
    localparam int unsigned MS_CYC   = SYS_FREQ / 1000;
    localparam int unsigned BIT_CYC  = SYS_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s1, s2, s3, enable;
    logic [1:0] epass;
    logic       barrier, sdo;

    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    toll_speed_gate #(
        .SYS_FREQ   (SYS_FREQ),
        .BAUD       (BAUD),
        .WIDTH_SPEED(14)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor1        (s1),
        .sensor2        (s2),
        .sensor3        (s3),
        .valid_Epass    (epass),
        .enable         (enable),
        .barrier        (barrier),
        .serial_data_out(sdo)
    );

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // UART line decoder: pops the scoreboard at each received byte.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       ok;
        forever begin
            @(negedge clk);
            if (mon_en && !reset_n && sdo === 1'b0) begin
                ok = 1'b1;
                b  = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    if (reset_n) ok = 1'b0;
                    b[i] = sdo;
                end
                repeat (BIT_CYC) @(negedge clk);
                if (reset_n) ok = 1'b0;
                if (ok) begin
                    checks++;
                    if (sdo !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: got %b want 1", sdo);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%02h want none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            errors++;
                            $display("FAIL rx_byte: got 0x%02h want 0x%02h", b, e);
                        end
                    end
                end
            end
        end
    end

    function automatic int model_speed(int t_ms);
        int q;
        if (t_ms == 0) return 16383;
        q = 360000 / t_ms;
        return (q > 16383) ? 16383 : q;
    endfunction

    task automatic drive_pass(int gap_cycles);
        @(negedge clk);
        s1 = 1'b1;
        repeat (gap_cycles) @(negedge clk);
        s3 = 1'b1;
        repeat (5) @(negedge clk);
        s1 = 1'b0;
        s3 = 1'b0;
    endtask

    task automatic test_pass(string name, int gap_cycles);
        logic [15:0] sp;
        int n;
        checks++;
        if (sdo !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_before: got %b want 1", name, sdo);
        end
        sp = 16'(model_speed(gap_cycles / MS_CYC));
        exp_q.push_back(sp[15:8]);
        exp_q.push_back(sp[7:0]);
        drive_pass(gap_cycles);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d bytes pending want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2 * BIT_CYC) @(negedge clk);
        checks++;
        if (sdo !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_after: got %b want 1", name, sdo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        epass = 2'b00;
        enable = 1'b1;
        #1;
        checks++;
        if (barrier !== 1'b1) begin
            errors++;
            $display("FAIL reset_enable_barrier: got %b want 1", barrier);
        end
        enable = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (barrier !== 1'b0) begin
            errors++;
            $display("FAIL reset_barrier: got %b want 0", barrier);
        end
        checks++;
        if (sdo !== 1'b1) begin
            errors++;
            $display("FAIL reset_serial: got %b want 1", sdo);
        end
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_barrier_valid();
        s2 = 1'b1;
        repeat (50 * MS_CYC) @(negedge clk);
        checks++;
        if (barrier !== 1'b0) begin
            errors++;
            $display("FAIL s2_only_barrier: got %b want 0", barrier);
        end
        epass = 2'b10;
        repeat (4) @(negedge clk);
        checks++;
        if (barrier !== 1'b1) begin
            errors++;
            $display("FAIL valid_open: got %b want 1", barrier);
        end
        repeat (10) @(negedge clk);
        epass = 2'b00;
        s2 = 1'b0;
        repeat (10) @(negedge clk);
        s3 = 1'b1;
        repeat (144 * MS_CYC) @(negedge clk);
        checks++;
        if (barrier !== 1'b1) begin
            errors++;
            $display("FAIL hold_open: got %b want 1", barrier);
        end
        s3 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (barrier !== 1'b0) begin
            errors++;
            $display("FAIL s3_fall_close: got %b want 0", barrier);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_barrier_invalid();
        logic [1:0] codes [3];
        codes[0] = 2'b01;
        codes[1] = 2'b00;
        codes[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            s2 = 1'b1;
            repeat (50 * MS_CYC) @(negedge clk);
            epass = codes[k];
            repeat (10) @(negedge clk);
            checks++;
            if (barrier !== 1'b0) begin
                errors++;
                $display("FAIL invalid_epass_%b: got %b want 0", codes[k], barrier);
            end
            epass = 2'b00;
            s2 = 1'b0;
            s3 = 1'b1;
            repeat (20) @(negedge clk);
            s3 = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_enable();
        enable = 1'b1;
        #1;
        checks++;
        if (barrier !== 1'b1) begin
            errors++;
            $display("FAIL enable_open: got %b want 1", barrier);
        end
        repeat (20) @(negedge clk);
        enable = 1'b0;
        #1;
        checks++;
        if (barrier !== 1'b0) begin
            errors++;
            $display("FAIL enable_release: got %b want 0", barrier);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        int lows = 0;
        @(negedge clk);
        s1 = 1'b1;
        for (int i = 0; i < 8200 * int'(MS_CYC); i++) begin
            @(negedge clk);
            if (sdo !== 1'b1) lows++;
        end
        s1 = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL timeout_silent: got %0d low samples want 0", lows);
        end
        test_pass("after_timeout", 1600 * MS_CYC);
    endtask

    task automatic test_reset_mid_byte();
        int n;
        mon_en = 1'b0;
        drive_pass(400 * MS_CYC);
        repeat (2) @(negedge clk);
        s2 = 1'b1;
        epass = 2'b10;
        n = 0;
        while (sdo !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL frame_start: got no start bit want start within 500 cycles");
        end
        checks++;
        if (barrier !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_open: got %b want 1", barrier);
        end
        reset_n = 1'b1;
        s2 = 1'b0;
        epass = 2'b00;
        #1;
        checks++;
        if (sdo !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_serial: got %b want 1", sdo);
        end
        checks++;
        if (barrier !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_barrier: got %b want 0", barrier);
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete();
        mon_en = 1'b1;
        test_pass("after_reset", 800 * MS_CYC);
    endtask

    initial begin
        test_reset();
        test_pass("pass_1600ms", 1600 * MS_CYC);
        test_pass("pass_1200ms", 1200 * MS_CYC);
        test_pass("truncate_1600ms", 1600 * MS_CYC + 2);
        test_pass("unsat_22ms", 22 * MS_CYC);
        test_pass("sat_21ms", 21 * MS_CYC);
        test_pass("zero_t", 1);
        test_barrier_valid();
        test_barrier_invalid();
        test_enable();
        test_timeout();
        test_reset_mid_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toll_speed_gate.md
# toll_speed_gate

Single-lane toll/speed station controller. It times a vehicle across three road sensors and computes its speed in 0.1 km/h units. It transmits the speed as a two-byte UART frame and drives the toll barrier from an E-pass reader verdict. It is the chip-level top of the roadside controller.

## Interface
- `SYS_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate; bit period = SYS_FREQ/BAUD cycles, integer-truncated (434 at default).
- `WIDTH_SPEED`, 14: speed result width.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset is asynchronous and active-high. The port keeps the codebase reset name, but it is asserted when 1.
- `sensor1`, `sensor2`, `sensor3` in 1 each: asynchronous presence sensors, 1 = vehicle over sensor. Spacing: s1→s2 4 m, s2→s3 6 m (s1→s3 10 m).
- `valid_Epass` in 2: reader verdict. 2'b10 = valid pass, 2'b01 = invalid, 2'b00/2'b11 = no read.
- `enable` in 1: manual barrier override, 1 = force open.
- `barrier` out 1: 1 = barrier open.
- `serial_data_out` out 1: UART TX line, 8N1, LSB first, idle high.

## Operation
- Inputs are synchronized:
  - `sensor*` and `valid_Epass` each pass through 2 flops; rising and falling edges are taken from the synchronized values.
  - `enable` is used directly.
- Millisecond tick: 16-bit prescaler counts 0..SYS_FREQ/1000−1 and pulses `ms_tick` on wrap. The prescaler is cleared on every s1 rising edge, so the timing phase starts there.
- Measurement FSM states: IDLE, TIMING, DIVIDE, SEND.
  - IDLE → TIMING on s1 rise; the 13-bit ms counter `t` is cleared.
  - TIMING: `t` increments on each `ms_tick`. s1 edges are ignored.
  - TIMING → DIVIDE on s3 rise.
  - TIMING → IDLE if `t` reaches 8191 (timeout). Nothing is sent.
  - DIVIDE: unsigned `speed = 360000 / t`, integer quotient.
    - `t = 0` gives 16383.
    - A quotient > 16383 saturates to 16383.
  - DIVIDE → SEND when the divider asserts done.
  - SEND: zero-extend speed to 16 bits and transmit the high byte, then the low byte, back-to-back. Each byte is start(0), 8 data bits LSB-first, stop(1). Return to IDLE after the second stop bit.
  - Sensor edges arriving during DIVIDE or SEND are ignored.
- Barrier FSM states: CLOSED, OPEN.
  - CLOSED → OPEN when synchronized s2 = 1 and synchronized `valid_Epass` = 2'b10 in the same cycle.
  - OPEN → CLOSED on s3 falling edge.
  - `valid_Epass` of 2'b01, 00 or 11 never opens the barrier.
  - `barrier = (state == OPEN) | enable`. The override does not change the FSM state.
- Reset, asynchronous, any time including mid-frame:
  - Both FSMs go to IDLE/CLOSED and all counters go to 0.
  - `barrier` = 0 (unless `enable` = 1); `serial_data_out` = 1 immediately.

## Timing
- Sensor edge → internal event: 2 cycles of synchronizer plus 1 edge-detect cycle.
- Time resolution: 1 ms. The measured `t` is the number of whole ms between the two synchronized rising edges, truncated toward zero.
- Divider: restoring, 19-bit dividend (360000), 13-bit divisor, 1 quotient bit per cycle, done 20 cycles after start.
- The UART start bit begins the cycle after divider done.
- Frame length: 20 × bit period (8680 cycles at default). No gap between bytes.
- The barrier opens within 4 cycles of the qualifying input change and closes within 4 cycles of the s3 fall.

## Structure
- Shared package constants:
  - `DIST_CONST = 360000` (10 m → 0.1 km/h with ms timing).
  - `T_WIDTH = 13`, `SPEED_MAX = 16383`.
  - `EPASS_VALID = 2'b10`, `EPASS_INVALID = 2'b01`.
  - FSM state enums.
- Sub-modules:
  - `seq_divider`: unsigned restoring divider with start/done handshake.
  - `uart_tx`: byte-wide start/busy handshake, BAUD-parameterized.
- The top contains the synchronizers, tick prescaler, and both FSMs.

## Test plan
- s1 rise at t0, s3 rise at t0+1600 ms, `enable` = 0 → speed 225 (22.5 km/h). Serial bytes are 0x00 then 0xE1; line idle high before and after.
- s1 rise, s3 rise 1200 ms later → speed 300. Bytes 0x01, 0x2C.
- s2 high, then `valid_Epass` = 2'b10 50 ms later → `barrier` = 1 within 4 cycles. s3 pulse 144 ms; on its fall `barrier` = 0.
- Same sequence with `valid_Epass` = 2'b01 → `barrier` stays 0. With `enable` = 1 → `barrier` = 1 regardless, and returns to 0 when `enable` drops.
- s1 rise with no s3 for 8.2 s → timeout: no serial activity, FSM back in IDLE. A following 1600 ms pass still yields 0x00, 0xE1.
- Assert `reset_n` mid-byte → `serial_data_out` = 1 and `barrier` = 0 at once. After release, a new pass transmits correctly.
